// File: rtl/comp_addsub_stream.sv
// comp_addsub_stream: two-stage streaming complex add/sub (a +/- b, a +/- conj(b)).
// Lane 1 carries the real part, lane 0 the imag part, matching the {real, imag} packing.

// Combinational IEEE-754 adder with round-to-nearest-even and subnormal support.
module fpu_add #(
  parameter int double = 0,
  localparam int SIZE = (double != 0) ? 64 : 32
) (
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] b_i,
  output logic [SIZE-1:0] sum_o
);
  localparam int EW = (double != 0) ? 11 : 8;
  localparam int MW = SIZE - EW - 1;
  localparam int XW = MW + 5;  // carry + hidden + fraction + guard/round/sticky

  logic            sa, sb, sl, ss, swap, sub, up;
  logic            a_nan, b_nan, a_inf, b_inf;
  logic [EW-1:0]   ea, eb, el, es;
  logic [MW-1:0]   fa, fb, fl, fs;
  logic [EW:0]     el_eff, es_eff, d, lz, sh, ex, fld;
  logic [XW-1:0]   ml, ms, al, s;
  logic [2*XW-1:0] wide;
  logic [XW-2:0]   n;
  logic [MW+1:0]   r;

  // Align the smaller magnitude, add/subtract, normalise, round, then patch specials.
  always_comb begin
    sh = '0;
    sa = a_i[SIZE-1];  ea = a_i[SIZE-2 -: EW];  fa = a_i[MW-1:0];
    sb = b_i[SIZE-1];  eb = b_i[SIZE-2 -: EW];  fb = b_i[MW-1:0];
    a_nan = (ea == '1) && (fa != '0);
    b_nan = (eb == '1) && (fb != '0);
    a_inf = (ea == '1) && (fa == '0);
    b_inf = (eb == '1) && (fb == '0);
    swap = (b_i[SIZE-2:0] > a_i[SIZE-2:0]);
    sl = swap ? sb : sa;  el = swap ? eb : ea;  fl = swap ? fb : fa;
    ss = swap ? sa : sb;  es = swap ? ea : eb;  fs = swap ? fa : fb;
    el_eff = (el == '0) ? (EW+1)'(1) : {1'b0, el};
    es_eff = (es == '0) ? (EW+1)'(1) : {1'b0, es};
    ml = {1'b0, (el != '0), fl, 3'b000};
    ms = {1'b0, (es != '0), fs, 3'b000};
    d = el_eff - es_eff;
    // Bits shifted past the guard/round positions collapse into the sticky bit.
    wide = {ms, {XW{1'b0}}} >> ((d > (EW+1)'(XW)) ? (EW+1)'(XW) : d);
    al = wide[2*XW-1:XW] | {{(XW-1){1'b0}}, |wide[XW-1:0]};
    sub = sl ^ ss;
    s = sub ? (ml - al) : (ml + al);
    lz = (EW+1)'(XW-1);
    for (int i = 0; i < XW-1; i++) if (s[i]) lz = (EW+1)'(XW-2-i);
    if (s[XW-1]) begin
      n  = {s[XW-1:2], |s[1:0]};
      ex = el_eff + 1'b1;
    end else begin
      // Stop left-normalising at the minimum exponent so tiny results go subnormal.
      sh = (lz < el_eff - 1'b1) ? lz : el_eff - 1'b1;
      n  = s[XW-2:0] << sh;
      ex = el_eff - sh;
    end
    up  = n[2] & (n[1] | n[0] | n[3]);
    r   = {1'b0, n[XW-2:3]} + {{(MW+1){1'b0}}, up};
    fld = r[MW+1] ? ex + 1'b1 : (r[MW] ? ex : '0);
    if (fld >= {1'b0, {EW{1'b1}}})
      sum_o = {sl, {EW{1'b1}}, {MW{1'b0}}};
    else
      sum_o = {(sub && (s == '0)) ? 1'b0 : sl, fld[EW-1:0], r[MW-1:0]};
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
      sum_o = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    else if (a_inf)
      sum_o = a_i;
    else if (b_inf)
      sum_o = b_i;
  end
endmodule

module comp_addsub_stream #(
  parameter int double = 0,
  parameter int TAG_W  = 4,
  localparam int SIZE  = (double != 0) ? 64 : 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*SIZE-1:0] in_a,
  input  logic [2*SIZE-1:0] in_b,
  input  logic [1:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*SIZE-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        out_exc
);
  localparam int EW    = (double != 0) ? 11 : 8;
  localparam int LANES = 2;

  logic                        en;
  logic [2:1]                  vld_pipe_q;
  logic [LANES-1:0][SIZE-1:0]  b_cond, a_q, b_q, sum_d, sum_q;
  logic [TAG_W-1:0]            tag1_q, tag2_q;
  logic [LANES-1:0]            exc_d, exc_q;

  // Global stall: both stages move together whenever the output slot can drain.
  assign en       = !vld_pipe_q[2] || out_ready;
  assign in_ready = en && !rst;

  // Conjugate/negate b by flipping sign bits only; Inf/NaN/zero pass through untouched.
  always_comb begin
    b_cond = in_b;
    b_cond[1][SIZE-1] = in_b[2*SIZE-1] ^ in_op[0];
    b_cond[0][SIZE-1] = in_b[SIZE-1] ^ in_op[1] ^ in_op[0];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fpu_add #(.double(double)) u_add (
      .a_i   (a_q[l]),
      .b_i   (b_q[l]),
      .sum_o (sum_d[l])
    );
    assign exc_d[l] = &sum_d[l][SIZE-2 -: EW];
  end

  // S1 captures conditioned operands, S2 captures sums; valid bits shift together.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      tag1_q     <= '0;
      sum_q      <= '0;
      tag2_q     <= '0;
      exc_q      <= '0;
    end else if (en) begin
      vld_pipe_q <= {vld_pipe_q[1], in_valid && in_ready};
      a_q        <= in_a;
      b_q        <= b_cond;
      tag1_q     <= in_tag;
      sum_q      <= sum_d;
      tag2_q     <= tag1_q;
      exc_q      <= exc_d;
    end
  end

  assign out_valid = vld_pipe_q[2];
  assign out_data  = sum_q;
  assign out_tag   = tag2_q;
  assign out_exc   = exc_q;
endmodule

// File: tb/tb_comp_addsub_stream.sv
// Directed bench for comp_addsub_stream with an expected-result queue.
module tb_comp_addsub_stream;
  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [63:0]  in_a, in_b, out_data;
  logic [1:0]   in_op, out_exc;
  logic [3:0]   in_tag, out_tag;
  logic         d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [127:0] d_in_a, d_in_b, d_out_data;
  logic [1:0]   d_in_op, d_out_exc;
  logic [3:0]   d_in_tag, d_out_tag;

  always #5 clk = ~clk;

  comp_addsub_stream #(.double(0), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_exc(out_exc));

  comp_addsub_stream #(.double(1), .TAG_W(4)) dut_d (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_a(d_in_a), .in_b(d_in_b), .in_op(d_in_op), .in_tag(d_in_tag),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
    .out_tag(d_out_tag), .out_exc(d_out_exc));

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
    logic [1:0]  exc;
    logic [63:0] mask;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, failures = 0, cyc = 0;
  bit          chk_lat, bp, prev_stall, dummy;
  logic [63:0] prev_data, nx_data, nx_mask;
  logic [3:0]  prev_tag;
  logic [1:0]  nx_exc;
  logic [31:0] ft[8];

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, update the model, step past the rising edge.
  task automatic cycle(output bit acc);
    exp_t e;
    @(negedge clk);
    acc = 1'b0;
    chk("in_ready", in_ready, (rst || (out_valid && !out_ready)) ? 1'b0 : 1'b1);
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, prev_data);
      chk("hold_tag", out_tag, prev_tag);
    end
    if (!rst && out_valid === 1'b1 && out_ready) begin
      if (sb.size() == 0) chk("stale_out", out_valid, 1'b0);
      else begin
        e = sb.pop_front();
        chk("out_data", out_data & e.mask, e.data & e.mask);
        chk("out_tag", out_tag, e.tag);
        chk("out_exc", out_exc, e.exc);
        if (chk_lat) chk("latency", cyc - e.acc, 2);
      end
    end
    if (!rst && in_valid && in_ready) begin
      acc = 1'b1;
      sb.push_back('{nx_data, in_tag, nx_exc, nx_mask, cyc});
    end
    prev_stall = !rst && out_valid === 1'b1 && !out_ready;
    prev_data  = out_data;
    prev_tag   = out_tag;
    @(posedge clk);
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end
    cyc++;
    #1;
    if (bp) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                      input logic [3:0] tag, input logic [63:0] ed, input logic [1:0] ee,
                      input logic [63:0] m);
    bit acc = 1'b0;
    in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1;
    nx_data = ed; nx_exc = ee; nx_mask = m;
    for (int k = 0; k < 20 && !acc; k++) cycle(acc);
    if (!acc) chk("send_timeout", in_ready, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sb.size() > 0; k++) cycle(dummy);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    ft[0] = 32'h00000000; ft[1] = 32'h3F800000; ft[2] = 32'h40000000; ft[3] = 32'h40400000;
    ft[4] = 32'h40800000; ft[5] = 32'h40A00000; ft[6] = 32'h40C00000; ft[7] = 32'h40E00000;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1; chk_lat = 1'b0; bp = 1'b0; prev_stall = 1'b0;
    nx_data = '0; nx_exc = '0; nx_mask = '1;
    d_in_valid = 1'b0; d_in_a = '0; d_in_b = '0; d_in_op = '0; d_in_tag = '0; d_out_ready = 1'b1;

    // Reset state
    cycle(dummy); cycle(dummy);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 64'h0);
    chk("rst_tag", out_tag, 4'h0);
    chk("rst_exc", out_exc, 2'b00);
    rst = 1'b0;

    // Basic add with exact two-cycle latency
    chk_lat = 1'b1;
    send(64'h3F800000_40000000, 64'h40000000_3F800000, 2'b00, 4'd5, 64'h40400000_40400000, 2'b00, '1);
    drain();

    // All four ops back-to-back
    send(64'h3F800000_40000000, 64'h40000000_3F800000, 2'b01, 4'd1, 64'hBF800000_3F800000, 2'b00, '1);
    send(64'h3F800000_40000000, 64'h40000000_3F800000, 2'b10, 4'd2, 64'h40400000_3F800000, 2'b00, '1);
    send(64'h3F800000_40000000, 64'h40000000_3F800000, 2'b11, 4'd3, 64'hBF800000_40400000, 2'b00, '1);
    send(64'h40A00000_C0400000, 64'h3F800000_40000000, 2'b11, 4'd4, 64'h40800000_BF800000, 2'b00, '1);
    send(64'h40A00000_C0400000, 64'h3F800000_40000000, 2'b10, 4'd6, 64'h40C00000_C0A00000, 2'b00, '1);
    drain();

    // Exceptions: Inf in real, NaN in imag (NaN payload not checked)
    send(64'h7F800000_00000000, 64'h3F800000_00000000, 2'b00, 4'd7, 64'h7F800000_00000000, 2'b10, '1);
    send(64'h3F800000_7FC00000, 64'h3F800000_3F800000, 2'b00, 4'd8, 64'h40000000_00000000, 2'b01,
         64'hFFFFFFFF_00000000);
    drain();

    // Backpressure: out_ready follows 1-0-0-1
    chk_lat = 1'b0;
    bp = 1'b1;
    for (int k = 0; k < 8; k++)
      send({ft[k], 32'h3F800000}, {32'h00000000, 32'h3F800000}, 2'b00, 4'(k),
           {ft[k], 32'h40000000}, 2'b00, '1);
    drain();
    bp = 1'b0;
    out_ready = 1'b1;

    // Reset with two transactions in flight
    send(64'h3F800000_3F800000, 64'h3F800000_3F800000, 2'b00, 4'd9, 64'h40000000_40000000, 2'b00, '1);
    send(64'h40000000_40000000, 64'h3F800000_3F800000, 2'b00, 4'd10, 64'h40400000_40400000, 2'b00, '1);
    out_ready = 1'b0;
    rst = 1'b1;
    cycle(dummy);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_data", out_data, 64'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle(dummy);
    chk_lat = 1'b1;
    send(64'h40400000_3F800000, 64'h3F800000_40400000, 2'b01, 4'd11, 64'h40000000_C0000000, 2'b00, '1);
    drain();

    // Double-precision build
    d_in_a = {64'h3FF0000000000000, 64'h4000000000000000};
    d_in_b = {64'h4000000000000000, 64'h3FF0000000000000};
    d_in_op = 2'b00; d_in_tag = 4'd3; d_in_valid = 1'b1;
    chk("d_in_ready", d_in_ready, 1'b1);
    cycle(dummy);
    d_in_valid = 1'b0;
    cycle(dummy);
    chk("d_out_valid", d_out_valid, 1'b1);
    chk("d_out_data", d_out_data, {64'h4008000000000000, 64'h4008000000000000});
    chk("d_out_tag", d_out_tag, 4'd3);
    chk("d_out_exc", d_out_exc, 2'b00);
    cycle(dummy);
    chk("d_out_idle", d_out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
